// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: owner encoding
// and default bus widths used by the core-side and loader-side logic.
package mem_port_arbiter_pkg;

    // Previous-cycle owner of the memory port, also used as the FSM state.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CORE = 2'b01,
        OWN_LDR  = 2'b10,
        OWN_BOOT = 2'b11
    } owner_e;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Width of the lock counter; MAX_LOCK is limited to 1..255.
    localparam int LOCK_CNT_W = 8;

endpackage

// File: rtl/mem_rr_pick.sv
// Two-way round-robin picker with lock override.
// Bit 0 of every vector is the core, bit 1 is the loader.
module mem_rr_pick (
    input  logic [1:0] req,
    input  logic [1:0] lock,        // lock asserted by the previous owner only
    input  logic       last_ldr,    // 1: loader was granted most recently
    input  logic       lock_sat,    // lock budget used up
    output logic [1:0] gnt,
    output logic       locked_pick  // grant came from the lock rule
);

    // Single requester wins; on a tie the lock holder keeps the port until
    // the budget runs out, otherwise the requester that was not last wins.
    always_comb begin
        gnt         = 2'b00;
        locked_pick = 1'b0;
        unique case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                if (lock[0] && !lock_sat) begin
                    gnt         = 2'b01;
                    locked_pick = 1'b1;
                end else if (lock[1] && !lock_sat) begin
                    gnt         = 2'b10;
                    locked_pick = 1'b1;
                end else if (last_ldr) begin
                    gnt = 2'b01;
                end else begin
                    gnt = 2'b10;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single instruction/data memory between the multicycle core
// and the boot/debug loader. One access per cycle, registered read data with
// a one-cycle rvalid pulse, and a stall signal for the core FSM.
//
// Handshake: a requester raises X_req with X_we/X_addr/X_wdata and holds them
// stable until X_gnt is high in the same cycle; the access happens at the
// clock edge ending that cycle. Dropping X_req before a grant is harmless.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_LOCK = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_hold,
    input  logic              c_req,
    input  logic              c_we,
    input  logic              c_lock,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              stall_core,
    input  logic              l_req,
    input  logic              l_we,
    input  logic              l_lock,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic [1:0]        owner
);

    localparam logic [LOCK_CNT_W-1:0] MAX_LOCK_L = LOCK_CNT_W'(MAX_LOCK);

    owner_e                state;
    logic                  last_ldr;
    logic [LOCK_CNT_W-1:0] lock_cnt;

    logic [1:0] pick_gnt;
    logic       locked_pick;
    logic       both_req;

    assign both_req = c_req & l_req;
    assign owner    = state;

    mem_rr_pick u_pick (
        .req         ({l_req, c_req}),
        .lock        ({l_lock & (state == OWN_LDR), c_lock & (state == OWN_CORE)}),
        .last_ldr    (last_ldr),
        .lock_sat    (lock_cnt >= MAX_LOCK_L),
        .gnt         (pick_gnt),
        .locked_pick (locked_pick)
    );

    // Grants: nothing during reset, loader-only while boot_hold, else picker.
    always_comb begin
        c_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!rst) begin
            if (boot_hold) begin
                l_gnt = l_req;
            end else begin
                c_gnt = pick_gnt[0];
                l_gnt = pick_gnt[1];
            end
        end
    end

    assign stall_core = c_req & ~c_gnt;

    // Memory port follows the granted requester; idle bus is all zero.
    always_comb begin
        mem_a  = '0;
        mem_we = 1'b0;
        mem_wd = '0;
        if (c_gnt) begin
            mem_a  = c_addr;
            mem_we = c_we;
            mem_wd = c_wdata;
        end else if (l_gnt) begin
            mem_a  = l_addr;
            mem_we = l_we;
            mem_wd = l_wdata;
        end
    end

    // Owner FSM, round-robin history, lock counter and read responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OWN_NONE;
            last_ldr <= 1'b1;
            lock_cnt <= '0;
            c_rvalid <= 1'b0;
            l_rvalid <= 1'b0;
            c_rdata  <= '0;
            l_rdata  <= '0;
        end else begin
            c_rvalid <= c_gnt & ~c_we;
            l_rvalid <= l_gnt & ~l_we;
            if (c_gnt && !c_we) c_rdata <= mem_rd;
            if (l_gnt && !l_we) l_rdata <= mem_rd;

            if (boot_hold) begin
                // Leaving BOOT must let the core win the first tie.
                state    <= OWN_BOOT;
                last_ldr <= 1'b1;
                lock_cnt <= '0;
            end else if (c_gnt || l_gnt) begin
                state    <= c_gnt ? OWN_CORE : OWN_LDR;
                last_ldr <= l_gnt;
                if (!both_req)       lock_cnt <= '0;
                else if (locked_pick) lock_cnt <= lock_cnt + 1'b1;
                else                 lock_cnt <= LOCK_CNT_W'(1);
            end else begin
                state    <= OWN_NONE;
                lock_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small word-addressed memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_hold;
  logic        c_req, c_we, c_lock;
  logic [31:0] c_addr, c_wdata;
  logic        c_gnt, c_rvalid, stall_core;
  logic [31:0] c_rdata;
  logic        l_req, l_we, l_lock;
  logic [31:0] l_addr, l_wdata;
  logic        l_gnt, l_rvalid;
  logic [31:0] l_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;
  logic [1:0]  owner;

  logic [31:0] mem [0:63];

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset block
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst), .boot_hold(boot_hold),
    .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .stall_core(stall_core),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd), .owner(owner)
  );

  // memory model: combinational read, write at the clock edge
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance past the next rising edge; inputs change here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sample point, away from the rising edge
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    boot_hold = 0;
    c_req = 0; c_we = 0; c_lock = 0; c_addr = 0; c_wdata = 0;
    l_req = 0; l_we = 0; l_lock = 0; l_addr = 0; l_wdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  logic exp_core_alt [6];
  logic exp_core_lock [7];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h00A00093;   // 0x10
    mem[8] = 32'h11111111;   // 0x20
    idle_inputs();

    // reset state
    do_reset();
    sample();
    check("rst_owner", {30'b0, owner}, 32'h0);
    check("rst_c_gnt", {31'b0, c_gnt}, 32'h0);
    check("rst_rvalid", {30'b0, c_rvalid, l_rvalid}, 32'h0);
    check("rst_rdata", c_rdata | l_rdata, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_mem_a", mem_a, 32'h0);

    // core read, one cycle latency
    step();
    c_req = 1; c_addr = 32'h10;
    sample();
    check("rd_c_gnt", {31'b0, c_gnt}, 32'h1);
    check("rd_mem_a", mem_a, 32'h10);
    check("rd_stall", {31'b0, stall_core}, 32'h0);
    step();
    c_req = 0;
    sample();
    check("rd_c_rvalid", {31'b0, c_rvalid}, 32'h1);
    check("rd_c_rdata", c_rdata, 32'h00A00093);
    check("rd_owner", {30'b0, owner}, 32'h1);
    step();
    sample();
    check("rd_rvalid_pulse", {31'b0, c_rvalid}, 32'h0);

    // tie from reset, no locks: strict alternation starting with the core
    exp_core_alt = '{1, 0, 1, 0, 1, 0};
    do_reset();
    c_req = 1; c_addr = 32'h10;
    l_req = 1; l_addr = 32'h20;
    for (int i = 0; i < 6; i++) begin
      sample();
      check($sformatf("alt_c_gnt%0d", i), {31'b0, c_gnt}, {31'b0, exp_core_alt[i]});
      check($sformatf("alt_l_gnt%0d", i), {31'b0, l_gnt}, {31'b0, ~exp_core_alt[i]});
      check($sformatf("alt_stall%0d", i), {31'b0, stall_core}, {31'b0, ~exp_core_alt[i]});
      step();
    end
    sample();
    check("alt_l_rdata", l_rdata, 32'h11111111);

    // core lock with MAX_LOCK=4: four core grants, one loader, then core again
    exp_core_lock = '{1, 1, 1, 1, 0, 1, 1};
    do_reset();
    c_req = 1; c_lock = 1; c_addr = 32'h10;
    l_req = 1; l_addr = 32'h20;
    for (int i = 0; i < 7; i++) begin
      sample();
      check($sformatf("lock_c_gnt%0d", i), {31'b0, c_gnt}, {31'b0, exp_core_lock[i]});
      check($sformatf("lock_l_gnt%0d", i), {31'b0, l_gnt}, {31'b0, ~exp_core_lock[i]});
      step();
    end

    // boot_hold: loader writes, core blocked, then core reads back
    do_reset();
    boot_hold = 1;
    l_req = 1; l_we = 1; l_addr = 32'h40; l_wdata = 32'hDEADBEEF;
    c_req = 1; c_addr = 32'h40;
    sample();
    check("boot_c_gnt", {31'b0, c_gnt}, 32'h0);
    check("boot_stall", {31'b0, stall_core}, 32'h1);
    check("boot_l_gnt", {31'b0, l_gnt}, 32'h1);
    check("boot_mem_we", {31'b0, mem_we}, 32'h1);
    check("boot_mem_a", mem_a, 32'h40);
    check("boot_mem_wd", mem_wd, 32'hDEADBEEF);
    step();
    l_req = 0; l_we = 0;
    sample();
    check("boot_c_gnt2", {31'b0, c_gnt}, 32'h0);
    check("boot_stall2", {31'b0, stall_core}, 32'h1);
    check("boot_owner", {30'b0, owner}, 32'h3);
    check("boot_l_rvalid", {31'b0, l_rvalid}, 32'h0);
    step();
    boot_hold = 0;
    sample();
    check("post_boot_c_gnt", {31'b0, c_gnt}, 32'h1);
    step();
    c_req = 0;
    sample();
    check("post_boot_rvalid", {31'b0, c_rvalid}, 32'h1);
    check("post_boot_rdata", c_rdata, 32'hDEADBEEF);

    // core write: one mem_we cycle, no rvalid, idle bus zero afterwards
    step();
    c_req = 1; c_we = 1; c_addr = 32'h80; c_wdata = 32'h12345678;
    sample();
    check("wr_mem_we", {31'b0, mem_we}, 32'h1);
    check("wr_mem_wd", mem_wd, 32'h12345678);
    step();
    c_req = 0; c_we = 0; c_addr = 32'h0; c_wdata = 32'h0;
    sample();
    check("wr_idle_we", {31'b0, mem_we}, 32'h0);
    check("wr_idle_a", mem_a, 32'h0);
    check("wr_no_rvalid", {31'b0, c_rvalid}, 32'h0);
    check("wr_rdata_hold", c_rdata, 32'hDEADBEEF);
    check("wr_mem_content", mem[32], 32'h12345678);

    // reset right after a granted loader read; pending core write is blocked
    step();
    l_req = 1; l_addr = 32'h20;
    sample();
    check("rstmid_l_gnt", {31'b0, l_gnt}, 32'h1);
    step();
    l_req = 0;
    rst = 1;
    c_req = 1; c_we = 1; c_addr = 32'h84; c_wdata = 32'h00000055;
    sample();
    check("rstmid_c_gnt", {31'b0, c_gnt}, 32'h0);
    check("rstmid_mem_we", {31'b0, mem_we}, 32'h0);
    step();
    rst = 0;
    c_req = 0; c_we = 0;
    sample();
    check("rstmid_l_rvalid", {31'b0, l_rvalid}, 32'h0);
    check("rstmid_owner", {30'b0, owner}, 32'h0);
    check("rstmid_l_rdata", l_rdata, 32'h0);
    check("rstmid_no_write", mem[33], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
